// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// Sequences one loadable up-counter through a commanded run: a command is
// accepted over cmd_valid/cmd_ready, the start value is loaded, increments
// are paced by a prescaler, and carry pulses are counted until the requested
// number of wraps has completed, leaving the counter parked at 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cmd_valid/ready command handshake (ready only while idle)
//   cmd_start       value loaded into the counter
//   cmd_div         one increment every cmd_div+1 run cycles
//   cmd_rounds      carry pulses to run for (0 = load only)
//   pause           freezes prescaler and increments
//   abort           ends a run in progress (LOAD/RUN)
//   cnt_en/load/data drive the counter's en/load/data_in
//   cnt_carry       counter's registered carry_out
//   busy            LOAD or RUN
//   done            one-cycle pulse on normal completion
//   aborted         one-cycle pulse after an abort
//   wraps_done      carry pulses counted in the current/last run (saturating)
module counter_run_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 8,
    parameter int unsigned RND_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [RND_W-1:0] cmd_rounds,
    input  logic             pause,
    input  logic             abort,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_data,
    input  logic             cnt_carry,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [RND_W-1:0] wraps_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [RND_W-1:0] ONE_R = RND_W'(1);
    localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_start;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_div_cnt;
    logic [RND_W-1:0] r_rounds;
    logic [RND_W-1:0] r_wraps;
    logic             r_aborted;

    logic w_idle;
    logic w_load;
    logic w_run;
    logic w_tick;
    logic w_last_carry;
    logic w_abort;

    assign w_idle  = (r_state == S_IDLE);
    assign w_load  = (r_state == S_LOAD);
    assign w_run   = (r_state == S_RUN);
    assign w_tick  = (r_div_cnt == r_div);
    assign w_abort = abort & (w_load | w_run);

    // The carry arrives one cycle after the wrap edge, so the increment in the
    // cycle the final carry is seen must be suppressed to leave the count at 0.
    assign w_last_carry = cnt_carry & (r_wraps == (r_rounds - ONE_R));

    assign cmd_ready  = w_idle;
    assign busy       = w_load | w_run;
    assign done       = (r_state == S_DONE);
    assign cnt_load   = w_load;
    assign cnt_data   = r_start;
    assign cnt_en     = w_run & w_tick & ~pause & ~w_last_carry & ~abort;
    assign aborted    = r_aborted;
    assign wraps_done = r_wraps;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_start   <= '0;
            r_div     <= '0;
            r_div_cnt <= '0;
            r_rounds  <= '0;
            r_wraps   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_start  <= cmd_start;
                        r_div    <= cmd_div;
                        r_rounds <= cmd_rounds;
                        r_wraps  <= '0;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_div_cnt <= '0;
                        r_state   <= (r_rounds == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Abort takes priority over everything, including a final
                    // carry in the same cycle; the wrap tally is left untouched.
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        if (!pause) begin
                            r_div_cnt <= w_tick ? '0 : (r_div_cnt + ONE_D);
                        end
                        // Carries are counted even while paused.
                        if (cnt_carry && (r_wraps != '1)) begin
                            r_wraps <= r_wraps + ONE_R;
                        end
                        if (w_last_carry) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Testbench for counter_run_ctrl: drives commands against a behavioural
// up-counter and checks run timing, increment count and end state against
// arithmetic expectations derived from the run parameters.
module tb_counter_run_ctrl;

    localparam int LIMIT = 5000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_div;
    logic [7:0] cmd_rounds;
    logic       pause;
    logic       abort;
    logic       cnt_en;
    logic       cnt_load;
    logic [7:0] cnt_data;
    logic       cnt_carry;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] wraps_done;

    // Environment: the loadable up-counter with registered carry_out.
    logic [7:0] q;

    int checks = 0;
    int failures = 0;

    counter_run_ctrl #(.WIDTH(8), .DIV_W(8), .RND_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_start  (cmd_start),
        .cmd_div    (cmd_div),
        .cmd_rounds (cmd_rounds),
        .pause      (pause),
        .abort      (abort),
        .cnt_en     (cnt_en),
        .cnt_load   (cnt_load),
        .cnt_data   (cnt_data),
        .cnt_carry  (cnt_carry),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .wraps_done (wraps_done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= '0;
            cnt_carry <= 1'b0;
        end else begin
            cnt_carry <= cnt_en && !cnt_load && (q == 8'hFF);
            if (cnt_load)    q <= cnt_data;
            else if (cnt_en) q <= q + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and watches the run until done/aborted or LIMIT.
    // Cycle 0 is the accept cycle; cycle 1 is LOAD.
    task automatic run_cmd(input logic [7:0] s, input logic [7:0] d, input logic [7:0] r,
                           input int pause_at, input int pause_len, input int abort_at,
                           output int done_cyc, output int abort_cyc,
                           output int en_cnt, output int en_paused);
        done_cyc  = -1;
        abort_cyc = -1;
        en_cnt    = 0;
        en_paused = 0;
        cmd_start  = s;
        cmd_div    = d;
        cmd_rounds = r;
        cmd_valid  = 1'b1;
        #1;
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        chk("load_pulse", 32'(cnt_load), 32'd1);
        chk("load_data", 32'(cnt_data), 32'(s));
        chk("busy_load", 32'(busy), 32'd1);
        chk("ready_busy", 32'(cmd_ready), 32'd0);
        chk("wraps_clr", 32'(wraps_done), 32'd0);
        for (int c = 1; c < LIMIT; c++) begin
            pause = (c >= pause_at) && (c < pause_at + pause_len);
            abort = (c == abort_at);
            #1;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (aborted) begin
                abort_cyc = c;
                break;
            end
            if (cnt_en) en_cnt++;
            if (cnt_en && pause) en_paused++;
            step();
        end
        pause = 1'b0;
        abort = 1'b0;
    endtask

    // Reference: a run of R rounds from S needs N increments, the last of
    // which wraps; done follows two cycles after that increment's cycle.
    function automatic int n_incs(input int s, input int r);
        return (256 - s) + (r - 1) * 256;
    endfunction

    function automatic int exp_done(input int s, input int d, input int r, input int paused);
        if (r == 0) return 2;
        return n_incs(s, r) * (d + 1) + 3 + paused;
    endfunction

    task automatic chk_done_end(input string tag, input int s, input int d, input int r,
                                input int paused, input int done_cyc, input int en_cnt);
        int exp_q;
        exp_q = (r == 0) ? s : 0;
        chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done(s, d, r, paused)));
        chk({tag, "_en_cnt"}, 32'(en_cnt), (r == 0) ? 32'd0 : 32'(n_incs(s, r)));
        chk({tag, "_count"}, 32'(q), 32'(exp_q));
        chk({tag, "_wraps"}, 32'(wraps_done), 32'(r));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        step();
        chk({tag, "_done_1cyc"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_data_hold"}, 32'(cnt_data), 32'(s));
    endtask

    initial begin
        int dc, ac, ec, ep;
        logic [7:0] rs, rd, rr;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_div = '0;
        cmd_rounds = '0;
        pause = 1'b0;
        abort = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_en", 32'(cnt_en), 32'd0);
        chk("rst_load", 32'(cnt_load), 32'd0);
        chk("rst_data", 32'(cnt_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_wraps", 32'(wraps_done), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Minimal run: FE, div 0, one round.
        run_cmd(8'hFE, 8'd0, 8'd1, 0, 0, 0, dc, ac, ec, ep);
        chk_done_end("fe", 8'hFE, 0, 1, 0, dc, ec);

        // Prescaled two-round run from 0.
        run_cmd(8'h00, 8'd2, 8'd2, 0, 0, 0, dc, ac, ec, ep);
        chk_done_end("div2", 0, 2, 2, 0, dc, ec);

        // Load-only command.
        run_cmd(8'h5A, 8'd3, 8'd0, 0, 0, 0, dc, ac, ec, ep);
        chk_done_end("r0", 8'h5A, 3, 0, 0, dc, ec);

        // Pause for 10 cycles mid-run.
        run_cmd(8'hF0, 8'd0, 8'd1, 6, 10, 0, dc, ac, ec, ep);
        chk("pause_no_en", 32'(ep), 32'd0);
        chk_done_end("pause", 8'hF0, 0, 1, 10, dc, ec);

        // Abort three cycles into RUN.
        run_cmd(8'h10, 8'd0, 8'd1, 0, 0, 4, dc, ac, ec, ep);
        chk("abort_cyc", 32'(ac), 32'd5);
        chk("abort_nodone", 32'(dc), 32'hFFFF_FFFF);
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        chk("abort_count", 32'(q), 32'h12);
        chk("abort_en_cnt", 32'(ec), 32'd2);
        step();
        chk("abort_1cyc", 32'(aborted), 32'd0);
        chk("abort_no_done_late", 32'(done), 32'd0);

        // Abort coinciding with the final carry.
        run_cmd(8'hFE, 8'd0, 8'd1, 0, 0, 4, dc, ac, ec, ep);
        chk("abcar_cyc", 32'(ac), 32'd5);
        chk("abcar_nodone", 32'(dc), 32'hFFFF_FFFF);
        chk("abcar_done_now", 32'(done), 32'd0);
        chk("abcar_wraps", 32'(wraps_done), 32'd0);
        chk("abcar_count", 32'(q), 32'd0);
        step();

        // Randomised complete runs.
        for (int i = 0; i < 6; i++) begin
            rs = 8'($urandom_range(0, 255));
            rd = 8'($urandom_range(0, 3));
            rr = 8'($urandom_range(1, 2));
            run_cmd(rs, rd, rr, 0, 0, 0, dc, ac, ec, ep);
            chk_done_end("rnd", int'(rs), int'(rd), int'(rr), 0, dc, ec);
        end

        // Asynchronous reset in the middle of a run.
        cmd_start = 8'hFE;
        cmd_div = 8'd0;
        cmd_rounds = 8'd3;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        repeat (5) step();
        chk("pre_rst_wraps", 32'(wraps_done), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(cmd_ready), 32'd1);
        chk("arst_en", 32'(cnt_en), 32'd0);
        chk("arst_load", 32'(cnt_load), 32'd0);
        chk("arst_data", 32'(cnt_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_aborted", 32'(aborted), 32'd0);
        chk("arst_wraps", 32'(wraps_done), 32'd0);
        step();
        rst = 1'b0;
        step();
        run_cmd(8'h33, 8'd1, 8'd0, 0, 0, 0, dc, ac, ec, ep);
        chk_done_end("post_rst", 8'h33, 1, 0, 0, dc, ec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
